// File: rtl/key_event_queue.sv
// PS/2 set-2 decoder for three "lane" keys feeding a small show-ahead event FIFO.
// Presses of a lane key (not typematic repeats) are queued; releases only clear held.
module key_event_queue #(
  parameter logic [7:0] KEY_ONE   = 8'h1C,
  parameter logic [7:0] KEY_TWO   = 8'h1B,
  parameter logic [7:0] KEY_THREE = 8'h23,
  parameter int         DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     code_valid,
  input  logic [7:0]               code,
  input  logic                     ev_pop,
  output logic                     ev_valid,
  output logic [1:0]               ev_lane,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic [2:0]               held,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX   = 8'hE0;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t          state;
  logic [1:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            key_hit;
  logic [1:0]      key_lane;
  logic            press;
  logic            fifo_full;
  logic            pop_ok;
  logic            do_push;
  logic            drop;

  always_comb begin
    key_hit  = 1'b1;
    key_lane = 2'd0;
    if (code == KEY_ONE)
      key_lane = 2'd0;
    else if (code == KEY_TWO)
      key_lane = 2'd1;
    else if (code == KEY_THREE)
      key_lane = 2'd2;
    else
      key_hit = 1'b0;
  end

  // A press is a fresh make code seen from IDLE; repeats of a held key are not events.
  assign press     = code_valid && (state == IDLE) && key_hit && !held[key_lane];
  assign fifo_full = (count == CW'(DEPTH));
  assign pop_ok    = ev_pop && (count != '0);
  assign do_push   = press && (!fifo_full || pop_ok);
  assign drop      = press && fifo_full && !pop_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      held     <= 3'b000;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 2'd0;
    end else begin
      if (code_valid) begin
        case (state)
          IDLE: begin
            if (code == BREAK_PREFIX)
              state <= BRK;
            else if (code == EXT_PREFIX)
              state <= EXT;
            else if (key_hit)
              held[key_lane] <= 1'b1;
          end
          BRK: begin
            if (code != BREAK_PREFIX) begin
              state <= IDLE;
              if (key_hit)
                held[key_lane] <= 1'b0;
            end
          end
          EXT: begin
            if (code == BREAK_PREFIX)
              state <= EXT_BRK;
            else
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end

      if (do_push) begin
        mem[wr_ptr] <= key_lane;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok)
        rd_ptr <= rd_ptr + PW'(1);

      if (do_push && !pop_ok)
        count <= count + CW'(1);
      else if (!do_push && pop_ok)
        count <= count - CW'(1);

      if (drop)
        overflow <= 1'b1;
    end
  end

  assign ev_lane  = mem[rd_ptr];
  assign ev_count = count;
  assign ev_valid = (count != '0);

endmodule

// File: tb/tb_key_event_queue.sv
// Directed self-checking bench for key_event_queue (DEPTH=4, default key codes).
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_key_event_queue;

  logic       clk;
  logic       reset;
  logic       code_valid;
  logic [7:0] code;
  logic       ev_pop;
  logic       ev_valid;
  logic [1:0] ev_lane;
  logic [2:0] ev_count;
  logic [2:0] held;
  logic       overflow;

  int checks = 0;
  int passed = 0;

  key_event_queue #(
    .KEY_ONE(8'h1C), .KEY_TWO(8'h1B), .KEY_THREE(8'h23), .DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code(code),
    .ev_pop(ev_pop), .ev_valid(ev_valid), .ev_lane(ev_lane),
    .ev_count(ev_count), .held(held), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus, driven from a falling edge and ending on the next one.
  task automatic applyStimulus(input logic valid, input logic [7:0] byte_in, input logic pop);
    code_valid = valid;
    code       = byte_in;
    ev_pop     = pop;
    @(negedge clk);
    code_valid = 1'b0;
    code       = 8'h00;
    ev_pop     = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] byte_in);
    applyStimulus(1'b1, byte_in, 1'b0);
  endtask

  task automatic popOne();
    applyStimulus(1'b0, 8'h00, 1'b1);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  initial begin
    reset      = 1'b1;
    code_valid = 1'b0;
    code       = 8'h00;
    ev_pop     = 1'b0;
    @(negedge clk);

    // Reset must win over simultaneous strobes.
    applyStimulus(1'b1, 8'h1C, 1'b1);
    applyStimulus(1'b1, 8'h1C, 1'b1);
    reset = 1'b0;
    checkOutput("rst_valid", 8'(ev_valid), 8'h0);
    checkOutput("rst_count", 8'(ev_count), 8'h0);
    checkOutput("rst_held", 8'(held), 8'h0);
    checkOutput("rst_ovf", 8'(overflow), 8'h0);
    checkOutput("rst_lane", 8'(ev_lane), 8'h0);

    // Single press and release of lane 0.
    sendByte(8'h1C);
    checkOutput("p1_held", 8'(held), 8'h1);
    checkOutput("p1_count", 8'(ev_count), 8'h1);
    checkOutput("p1_valid", 8'(ev_valid), 8'h1);
    checkOutput("p1_lane", 8'(ev_lane), 8'h0);
    sendByte(8'hF0);
    sendByte(8'h1C);
    checkOutput("r1_held", 8'(held), 8'h0);
    checkOutput("r1_count", 8'(ev_count), 8'h1);
    popOne();
    checkOutput("pop1_count", 8'(ev_count), 8'h0);
    checkOutput("pop1_valid", 8'(ev_valid), 8'h0);

    // Typematic repeats produce no extra events.
    sendByte(8'h1C);
    sendByte(8'h1C);
    sendByte(8'h1C);
    checkOutput("typ_count", 8'(ev_count), 8'h1);
    sendByte(8'hF0);
    sendByte(8'h1C);
    sendByte(8'h1C);
    checkOutput("typ_count2", 8'(ev_count), 8'h2);
    checkOutput("typ_held", 8'(held), 8'h1);
    checkOutput("typ_lane_a", 8'(ev_lane), 8'h0);
    popOne();
    checkOutput("typ_lane_b", 8'(ev_lane), 8'h0);
    popOne();
    checkOutput("typ_empty", 8'(ev_count), 8'h0);
    sendByte(8'hF0);
    sendByte(8'h1C);
    checkOutput("typ_rel", 8'(held), 8'h0);

    // Extended sequences never touch lanes; decoder lands back in IDLE.
    sendByte(8'hE0);
    sendByte(8'h1C);
    sendByte(8'hE0);
    sendByte(8'hF0);
    sendByte(8'h1C);
    checkOutput("ext_count", 8'(ev_count), 8'h0);
    checkOutput("ext_held", 8'(held), 8'h0);
    sendByte(8'hAA);
    sendByte(8'h1B);
    checkOutput("ext_idle_cnt", 8'(ev_count), 8'h1);
    checkOutput("ext_idle_lane", 8'(ev_lane), 8'h1);
    checkOutput("ext_idle_held", 8'(held), 8'h2);
    sendByte(8'hF0);
    sendByte(8'hF0);
    sendByte(8'h1B);
    checkOutput("dbl_f0_held", 8'(held), 8'h0);
    popOne();

    // Fill, then overflow on a fifth press.
    sendByte(8'h1C); sendByte(8'hF0); sendByte(8'h1C);
    sendByte(8'h1B); sendByte(8'hF0); sendByte(8'h1B);
    sendByte(8'h23); sendByte(8'hF0); sendByte(8'h23);
    sendByte(8'h1C);
    checkOutput("full_count", 8'(ev_count), 8'h4);
    checkOutput("full_ovf0", 8'(overflow), 8'h0);
    sendByte(8'h1B);
    checkOutput("ovf_count", 8'(ev_count), 8'h4);
    checkOutput("ovf_flag", 8'(overflow), 8'h1);
    checkOutput("ovf_held", 8'(held), 8'h3);
    checkOutput("ovf_lane0", 8'(ev_lane), 8'h0);
    popOne();
    checkOutput("ovf_lane1", 8'(ev_lane), 8'h1);
    popOne();
    checkOutput("ovf_lane2", 8'(ev_lane), 8'h2);
    popOne();
    checkOutput("ovf_lane3", 8'(ev_lane), 8'h0);
    popOne();
    checkOutput("ovf_drain", 8'(ev_count), 8'h0);
    popOne();
    checkOutput("empty_pop", 8'(ev_count), 8'h0);
    checkOutput("ovf_sticky", 8'(overflow), 8'h1);

    // Reset clears overflow; then push+pop on a full queue.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst2_ovf", 8'(overflow), 8'h0);
    checkOutput("rst2_held", 8'(held), 8'h0);
    sendByte(8'h1C); sendByte(8'hF0); sendByte(8'h1C);
    sendByte(8'h1B); sendByte(8'hF0); sendByte(8'h1B);
    sendByte(8'h23); sendByte(8'hF0); sendByte(8'h23);
    sendByte(8'h1C); sendByte(8'hF0); sendByte(8'h1C);
    applyStimulus(1'b1, 8'h1B, 1'b1);
    checkOutput("pp_count", 8'(ev_count), 8'h4);
    checkOutput("pp_ovf", 8'(overflow), 8'h0);
    checkOutput("pp_lane0", 8'(ev_lane), 8'h1);
    popOne();
    checkOutput("pp_lane1", 8'(ev_lane), 8'h2);
    popOne();
    checkOutput("pp_lane2", 8'(ev_lane), 8'h0);
    popOne();
    checkOutput("pp_lane3", 8'(ev_lane), 8'h1);
    popOne();
    checkOutput("pp_drain", 8'(ev_count), 8'h0);

    // Push with pop while empty: only the push lands.
    applyStimulus(1'b1, 8'h23, 1'b1);
    checkOutput("ep_count", 8'(ev_count), 8'h1);
    checkOutput("ep_lane", 8'(ev_lane), 8'h2);
    popOne();

    // A reset discards a pending break prefix.
    sendByte(8'hF0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sendByte(8'h1B);
    checkOutput("pfx_count", 8'(ev_count), 8'h1);
    checkOutput("pfx_lane", 8'(ev_lane), 8'h1);
    checkOutput("pfx_held", 8'(held), 8'h2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
